// File: rtl/board_vga_renderer_if.sv
// Board-in / VGA-out signal bundle for the Game of Life display stage.
// master = the renderer that drives the video pins; slave = the board source and video sink.
interface board_vga_renderer_if;
    logic [255:0] board_i;
    logic         hsync_o;
    logic         vsync_o;
    logic [3:0]   red_o;
    logic [3:0]   green_o;
    logic [3:0]   blue_o;
    logic         frame_start_o;

    modport master (
        input  board_i,
        output hsync_o, vsync_o, red_o, green_o, blue_o, frame_start_o
    );

    modport slave (
        output board_i,
        input  hsync_o, vsync_o, red_o, green_o, blue_o, frame_start_o
    );
endinterface

// File: rtl/board_vga_renderer.sv
// 640x480@60Hz renderer for a 16x16 Game of Life board, snapshotted once per frame at v=480.
// Optional feature: define GRID_LINES_EN to draw 12'h444 grid lines over the cells.
module board_vga_renderer #(
    parameter int          CLK_DIV  = 4,
    parameter int          CELL_PX  = 24,
    parameter logic [11:0] LIVE_RGB = 12'h0F0,
    parameter logic [11:0] DEAD_RGB = 12'h111
) (
    input  logic                 clk,
    input  logic                 reset,
    board_vga_renderer_if.master vga
);
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_VIS    = 640;
    localparam int V_VIS    = 480;
    localparam int H_SYNC_S = 656;
    localparam int H_SYNC_E = 751;
    localparam int V_SYNC_S = 490;
    localparam int V_SYNC_E = 491;
    localparam int SNAP_V   = 480;
    localparam int BOARD_PX = 16 * CELL_PX;
    localparam int X0       = (H_VIS - BOARD_PX) / 2;
    localparam int Y0       = (V_VIS - BOARD_PX) / 2;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SUB_W    = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [9:0]       r_h, r_v, w_h_next, w_v_next;
    logic             w_h_wrap;
    logic [SUB_W-1:0] r_hsub, r_vsub;
    logic [3:0]       r_col, r_row;
    logic [255:0]     r_snapshot;
    logic             w_vis, w_in_board;
    logic             r_s1_vis, r_s1_in_board, r_s1_hsync, r_s1_vsync;
    logic [7:0]       r_s1_idx;
    logic [11:0]      w_rgb, r_rgb;
    logic             r_hsync, r_vsync, r_frame_start;
`ifdef GRID_LINES_EN
    localparam logic [11:0] GRID_RGB = 12'h444;
    logic w_on_grid, r_s1_grid;
`endif

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    always_comb begin
        w_h_wrap = (r_h == 10'(H_TOTAL - 1));
        w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
        w_v_next = r_v;
        if (w_h_wrap) begin
            w_v_next = (r_v == 10'(V_TOTAL - 1)) ? 10'd0 : r_v + 10'd1;
        end
    end

    // Sub-cell counters restart at the board origin, so col/row fall out without dividers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_h    <= '0;
            r_v    <= '0;
            r_hsub <= '0;
            r_col  <= '0;
            r_vsub <= '0;
            r_row  <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                r_h <= w_h_next;
                r_v <= w_v_next;
                if (w_h_next == 10'(X0)) begin
                    r_hsub <= '0;
                    r_col  <= '0;
                end else if (r_hsub == SUB_W'(CELL_PX - 1)) begin
                    r_hsub <= '0;
                    r_col  <= r_col + 4'd1;
                end else begin
                    r_hsub <= r_hsub + SUB_W'(1);
                end
                if (w_h_wrap) begin
                    if (w_v_next == 10'(Y0)) begin
                        r_vsub <= '0;
                        r_row  <= '0;
                    end else if (r_vsub == SUB_W'(CELL_PX - 1)) begin
                        r_vsub <= '0;
                        r_row  <= r_row + 4'd1;
                    end else begin
                        r_vsub <= r_vsub + SUB_W'(1);
                    end
                end
            end
        end
    end

    assign w_vis      = (r_h < 10'(H_VIS)) && (r_v < 10'(V_VIS));
    assign w_in_board = (r_h >= 10'(X0)) && (r_h < 10'(X0 + BOARD_PX)) &&
                        (r_v >= 10'(Y0)) && (r_v < 10'(Y0 + BOARD_PX));
`ifdef GRID_LINES_EN
    // The closing lines at X0+BOARD_PX / Y0+BOARD_PX land on a zero sub-cell count too.
    assign w_on_grid  = (r_h >= 10'(X0)) && (r_h <= 10'(X0 + BOARD_PX)) &&
                        (r_v >= 10'(Y0)) && (r_v <= 10'(Y0 + BOARD_PX)) &&
                        ((r_hsub == '0) || (r_vsub == '0));
`endif

    always_comb begin
        w_rgb = 12'h000;
`ifdef GRID_LINES_EN
        if (r_s1_vis && r_s1_grid) begin
            w_rgb = GRID_RGB;
        end else if (r_s1_vis && r_s1_in_board) begin
            w_rgb = r_snapshot[r_s1_idx] ? LIVE_RGB : DEAD_RGB;
        end
`else
        if (r_s1_vis && r_s1_in_board) begin
            w_rgb = r_snapshot[r_s1_idx] ? LIVE_RGB : DEAD_RGB;
        end
`endif
    end

    // NOTE: the 256-bit snapshot is an ordinary register, not a RAM, so it takes the async
    // reset; that is what makes the first frame after reset show every cell dead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snapshot    <= '0;
            r_s1_vis      <= 1'b0;
            r_s1_in_board <= 1'b0;
            r_s1_idx      <= '0;
            r_s1_hsync    <= 1'b1;
            r_s1_vsync    <= 1'b1;
            r_rgb         <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
`ifdef GRID_LINES_EN
            r_s1_grid     <= 1'b0;
`endif
        end else begin
            r_frame_start <= w_tick && (r_h == 10'd0) && (r_v == 10'd0);
            if (w_tick) begin
                if ((r_h == 10'd0) && (r_v == 10'(SNAP_V))) begin
                    r_snapshot <= vga.board_i;
                end
                r_s1_vis      <= w_vis;
                r_s1_in_board <= w_in_board;
                r_s1_idx      <= {r_row, r_col};
                r_s1_hsync    <= !((r_h >= 10'(H_SYNC_S)) && (r_h <= 10'(H_SYNC_E)));
                r_s1_vsync    <= !((r_v >= 10'(V_SYNC_S)) && (r_v <= 10'(V_SYNC_E)));
`ifdef GRID_LINES_EN
                r_s1_grid     <= w_on_grid;
`endif
                r_rgb         <= w_rgb;
                r_hsync       <= r_s1_hsync;
                r_vsync       <= r_s1_vsync;
            end
        end
    end

    assign vga.hsync_o       = r_hsync;
    assign vga.vsync_o       = r_vsync;
    assign vga.red_o         = r_rgb[11:8];
    assign vga.green_o       = r_rgb[7:4];
    assign vga.blue_o        = r_rgb[3:0];
    assign vga.frame_start_o = r_frame_start;
endmodule

// File: tb/tb_board_vga_renderer.sv
// Self-checking bench for board_vga_renderer: a pixel model fed per tick into a scoreboard queue,
// popped one tick later against the DUT outputs at a grid of sampled pixel positions.
`timescale 1ns/1ps
module tb_board_vga_renderer;
    localparam int CLK_DIV    = 4;
    localparam int FRAME_CLKS = 800 * 525 * CLK_DIV;

    typedef struct {
        int          x;
        int          y;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } pix_t;

    logic clk;
    logic reset;
    board_vga_renderer_if vga();

    board_vga_renderer dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vga)
    );

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           t_fs = 0;
    int           mh = 0;
    int           mv = 0;
    int           ccnt = 0;
    bit           synced = 0;
    bit           prev_fs = 0;
    logic [255:0] m_snap = '0;
    logic [255:0] b_edge;
    pix_t         sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic pix_t model_pix(input int x, input int y, input logic [255:0] snap);
        pix_t p;
        int   bx, by;
        bit   grid;
        p.x   = x;
        p.y   = y;
        p.hs  = !(x >= 656 && x <= 751);
        p.vs  = !(y >= 490 && y <= 491);
        p.rgb = 12'h000;
        bx    = x - 128;
        by    = y - 48;
        grid  = 1'b0;
`ifdef GRID_LINES_EN
        grid = (bx >= 0 && bx <= 384 && by >= 0 && by <= 384 && (bx % 24 == 0 || by % 24 == 0));
`endif
        if (x < 640 && y < 480) begin
            if (grid) begin
                p.rgb = 12'h444;
            end else if (bx >= 0 && bx < 384 && by >= 0 && by < 384) begin
                p.rgb = snap[(by / 24) * 16 + bx / 24] ? 12'h0F0 : 12'h111;
            end
        end
        return p;
    endfunction

    function automatic bit is_sel(input int x, input int y);
        bit sx, sy;
        sx = x inside {0, 127, 128, 129, 151, 152, 153, 300, 487, 488, 489, 511, 512, 513,
                       639, 640, 655, 656, 657, 751, 752, 799};
        sy = y inside {0, 47, 48, 49, 71, 72, 200, 300, 407, 408, 431, 432, 433, 479, 480,
                       489, 490, 491, 492, 524};
        return sx && sy;
    endfunction

    // Scoreboard: push the model pixel for each tick, pop the previous one against the outputs.
    initial forever begin
        pix_t        e;
        logic [13:0] obs;
        @(posedge clk);
        b_edge = vga.board_i;
        #1;
        if (reset) begin
            synced  = 1'b0;
            prev_fs = 1'b0;
            m_snap  = '0;
            sb_q.delete();
            continue;
        end
        if (!synced) begin
            if (vga.frame_start_o === 1'b1) begin
                synced = 1'b1;
                mh     = 0;
                mv     = 0;
                ccnt   = 0;
                sb_q.push_back(model_pix(0, 0, m_snap));
            end
        end else begin
            ccnt++;
            if (ccnt == CLK_DIV) begin
                ccnt = 0;
                mh++;
                if (mh == 800) begin
                    mh = 0;
                    mv++;
                    if (mv == 525) mv = 0;
                end
                if (mh == 0 && mv == 480) m_snap = b_edge;
                if (mh == 0 && mv == 0) begin
                    checks++;
                    if (vga.frame_start_o !== 1'b1) begin
                        errors++;
                        $display("FAIL frame_start at (0,0): got %b required 1", vga.frame_start_o);
                    end
                end
                sb_q.push_back(model_pix(mh, mv, m_snap));
                if (sb_q.size() >= 2) begin
                    e = sb_q.pop_front();
                    if (is_sel(e.x, e.y)) begin
                        checks++;
                        obs = {vga.hsync_o, vga.vsync_o, vga.red_o, vga.green_o, vga.blue_o};
                        if (obs !== {e.hs, e.vs, e.rgb}) begin
                            errors++;
                            $display("FAIL pix(%0d,%0d): got hs=%b vs=%b rgb=%h required hs=%b vs=%b rgb=%h",
                                     e.x, e.y, obs[13], obs[12], obs[11:0], e.hs, e.vs, e.rgb);
                        end
                    end
                end
            end else if (prev_fs) begin
                checks++;
                if (vga.frame_start_o !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_start width: got %b required 0 one clk after pulse",
                             vga.frame_start_o);
                end
            end
        end
        prev_fs = vga.frame_start_o;
    end

    task automatic wait_pos(input int x, input int y);
        bit reached = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (synced && mh == x && mv == y) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL wait_pos(%0d,%0d): position not reached, required within %0d clks",
                     x, y, 2 * FRAME_CLKS);
        end
    endtask

    task automatic wait_frame_start(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (vga.frame_start_o === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({vga.hsync_o, vga.vsync_o, vga.red_o, vga.green_o, vga.blue_o, vga.frame_start_o}
            !== {1'b1, 1'b1, 12'h000, 1'b0}) begin
            errors++;
            $display("FAIL %s: got hs=%b vs=%b rgb=%h fs=%b required hs=1 vs=1 rgb=000 fs=0", tag,
                     vga.hsync_o, vga.vsync_o, {vga.red_o, vga.green_o, vga.blue_o},
                     vga.frame_start_o);
        end
    endtask

    task automatic test_reset();
        vga.board_i = '0;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_first_frame_start(input string tag);
        int n;
        wait_frame_start(4 * CLK_DIV, n);
        t_fs = cyc;
        checks++;
        if (n < 1 || n > CLK_DIV) begin
            errors++;
            $display("FAIL %s: frame_start after %0d clks, required 1..%0d", tag, n, CLK_DIV);
        end
    endtask

    // Change the board mid-frame: the current frame must keep the old snapshot.
    task automatic test_midframe_toggle(input logic [255:0] value);
        wait_pos(0, 200);
        vga.board_i = value;
    endtask

    task automatic test_frame_period();
        int n;
        wait_frame_start(FRAME_CLKS + 100, n);
        checks++;
        if (n < 0 || cyc - t_fs != FRAME_CLKS) begin
            errors++;
            $display("FAIL frame_period: got %0d clks required %0d", cyc - t_fs, FRAME_CLKS);
        end
    endtask

    task automatic test_reset_midframe();
        wait_pos(140, 300);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midframe_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_first_frame_start("frame_start_after_midframe_reset");
        wait_pos(0, 80);
    endtask

    initial begin
        test_reset();
        test_first_frame_start("frame_start_after_reset");
        test_midframe_toggle(256'd1 << 255);
        test_frame_period();
        test_midframe_toggle(256'd1);
        wait_pos(0, 450);
        wait_pos(0, 100);
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
